// File: rtl/gmux_bkl_pkg.sv
// Backlight level encoding shared by the gMUX PWM generator and the PWM duty decoder.
// Levels run 0..16; the threshold table holds the duty midpoints between generator steps.
package gmux_bkl_pkg;

    localparam int LEVEL_W    = 5;
    localparam int NUM_LEVELS = 17;
    localparam int THR_W      = 7;

    typedef logic [LEVEL_W-1:0] level_t;

    localparam level_t LEVEL_RESET = level_t'(10);
    localparam level_t LEVEL_MAX   = level_t'(NUM_LEVELS - 1);

    // Lower duty bound in percent for level k; k = 0 has no bound.
    function automatic logic [THR_W-1:0] bkl_thr(input level_t k);
        logic [THR_W-1:0] thr;
        case (k)
            5'd1:    thr = 7'd1;
            5'd2:    thr = 7'd2;
            5'd3:    thr = 7'd3;
            5'd4:    thr = 7'd5;
            5'd5:    thr = 7'd7;
            5'd6:    thr = 7'd9;
            5'd7:    thr = 7'd12;
            5'd8:    thr = 7'd16;
            5'd9:    thr = 7'd21;
            5'd10:   thr = 7'd26;
            5'd11:   thr = 7'd32;
            5'd12:   thr = 7'd38;
            5'd13:   thr = 7'd46;
            5'd14:   thr = 7'd56;
            5'd15:   thr = 7'd67;
            5'd16:   thr = 7'd81;
            default: thr = 7'd0;
        endcase
        return thr;
    endfunction

endpackage

// File: rtl/bkl_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin plus rise/fall detection.
// o_level is the edge-detect register, so it is still at the old value during an edge pulse.
module bkl_sync_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // NOTE: non-blocking assignments so each stage samples the previous stage's old value.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rise  =  r_sync & ~r_prev;
    assign o_fall  = ~r_sync &  r_prev;
    assign o_level =  r_prev;

endmodule

// File: rtl/pwm_duty_decoder.sv
// Measures the iGPU backlight PWM and quantizes its duty into backlight level 0..16.
// Optional: define PWM_DECODE_HYST_EN to require two matching results before LEVEL changes.
module pwm_duty_decoder
    import gmux_bkl_pkg::*;
#(
    parameter int CNT_W      = 20,
    parameter int MIN_PERIOD = 64,
    parameter int TIMEOUT    = 200000
) (
    input  logic   LPC_CLK33M_GMUX,
    input  logic   GMUX_RESET,
    input  logic   PWM_IN,
    output level_t LEVEL,
    output logic   LEVEL_UPD,
    output logic   LEVEL_VALID,
    output logic   PWM_IDLE
);

    localparam int PROD_W = CNT_W + 7;
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0]  MIN_P     = CNT_W'(MIN_PERIOD);
    localparam logic [PROD_W-1:0] PCT_SCALE = PROD_W'(100);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
    localparam logic [IDLE_W-1:0] IDLE_FULL = IDLE_W'(TIMEOUT);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMP  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic w_level;
    logic w_rise;
    logic w_fall;
    logic w_edge;

    bkl_sync_edge u_sync_edge (
        .i_clk   (LPC_CLK33M_GMUX),
        .i_rst   (GMUX_RESET),
        .i_async (PWM_IN),
        .o_level (w_level),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    assign w_edge = w_rise | w_fall;

    logic [CNT_W-1:0]  r_period_cnt;
    logic [CNT_W-1:0]  r_high_cnt;
    logic [IDLE_W-1:0] r_idle_cnt;
    logic              r_armed;
    logic [1:0]        r_state;
    level_t            r_k;
    level_t            r_result;
    logic [CNT_W-1:0]  r_p;
    logic [CNT_W-1:0]  r_h;
    level_t            r_level;
    logic              r_upd;
    logic              r_valid;
    logic              r_idle;

    logic [CNT_W-1:0]  w_p_next;
    logic              w_period_sat;
    logic              w_accept;
    logic              w_idle_hit;
    logic [PROD_W-1:0] w_lhs;
    logic [PROD_W-1:0] w_rhs;
    logic              w_pass;
    logic              w_write;

    assign w_p_next     = r_period_cnt + 1'b1;
    assign w_period_sat = &r_period_cnt;
    assign w_accept     = w_rise && r_armed && (r_state == ST_IDLE) &&
                          !w_period_sat && (w_p_next >= MIN_P);
    assign w_idle_hit   = !w_edge && (r_idle_cnt == IDLE_LAST);

    assign w_lhs  = PROD_W'(r_h) * PCT_SCALE;
    assign w_rhs  = PROD_W'(r_p) * PROD_W'(bkl_thr(r_k));
    assign w_pass = (w_lhs >= w_rhs);

    always_ff @(posedge LPC_CLK33M_GMUX or posedge GMUX_RESET) begin
        if (GMUX_RESET) begin
            r_period_cnt <= '0;
            r_high_cnt   <= '0;
            r_idle_cnt   <= '0;
            r_armed      <= 1'b0;
        end else begin
            if (w_rise) begin
                r_period_cnt <= '0;
                r_high_cnt   <= '0;
            end else begin
                if (!w_period_sat)
                    r_period_cnt <= r_period_cnt + 1'b1;
                if (w_level && !(&r_high_cnt))
                    r_high_cnt <= r_high_cnt + 1'b1;
            end

            if (w_edge)
                r_idle_cnt <= '0;
            else if (r_idle_cnt != IDLE_FULL)
                r_idle_cnt <= r_idle_cnt + 1'b1;

            // After an idle period the first rising edge only re-arms the measurement.
            if (w_idle_hit)
                r_armed <= 1'b0;
            else if (w_rise)
                r_armed <= 1'b1;
        end
    end

    // Linear search from the top level down; a rise during CMP/DONE is ignored by w_accept.
    always_ff @(posedge LPC_CLK33M_GMUX or posedge GMUX_RESET) begin
        if (GMUX_RESET) begin
            r_state  <= ST_IDLE;
            r_k      <= LEVEL_MAX;
            r_result <= '0;
            r_p      <= '0;
            r_h      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_p     <= w_p_next;
                        r_h     <= r_high_cnt;
                        r_k     <= LEVEL_MAX;
                        r_state <= ST_CMP;
                    end
                end
                ST_CMP: begin
                    if (w_pass) begin
                        r_result <= r_k;
                        r_state  <= ST_DONE;
                    end else if (r_k == level_t'(1)) begin
                        r_result <= '0;
                        r_state  <= ST_DONE;
                    end else begin
                        r_k <= r_k - 1'b1;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef PWM_DECODE_HYST_EN
    logic   r_pend_valid;
    level_t r_pend_val;

    always_ff @(posedge LPC_CLK33M_GMUX or posedge GMUX_RESET) begin
        if (GMUX_RESET) begin
            r_pend_valid <= 1'b0;
            r_pend_val   <= '0;
        end else if (w_idle_hit) begin
            r_pend_valid <= 1'b0;
        end else if (r_state == ST_DONE) begin
            r_pend_valid <= 1'b1;
            r_pend_val   <= r_result;
        end
    end

    assign w_write = (r_state == ST_DONE) && r_pend_valid && (r_pend_val == r_result);
`else
    assign w_write = (r_state == ST_DONE);
`endif

    always_ff @(posedge LPC_CLK33M_GMUX or posedge GMUX_RESET) begin
        if (GMUX_RESET) begin
            r_level <= LEVEL_RESET;
            r_upd   <= 1'b0;
            r_valid <= 1'b0;
            r_idle  <= 1'b0;
        end else begin
            r_upd <= 1'b0;
            if (w_idle_hit) begin
                r_idle  <= 1'b1;
                r_level <= w_level ? LEVEL_MAX : '0;
                r_upd   <= 1'b1;
                r_valid <= 1'b1;
            end else begin
                if (w_edge)
                    r_idle <= 1'b0;
                if (w_write) begin
                    r_level <= r_result;
                    r_upd   <= 1'b1;
                    r_valid <= 1'b1;
                end
            end
        end
    end

    assign LEVEL       = r_level;
    assign LEVEL_UPD   = r_upd;
    assign LEVEL_VALID = r_valid;
    assign PWM_IDLE    = r_idle;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Directed bench for pwm_duty_decoder; TIMEOUT is shortened so the idle case stays quick.
// The default build is exercised unless PWM_DECODE_HYST_EN is defined, which selects the filter sequence.
module tb_pwm_duty_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       pwm;
    logic [4:0] level;
    logic       level_upd;
    logic       level_valid;
    logic       pwm_idle;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int upd_cnt   = 0;
    int u0;

    always #5 clk = ~clk;

    pwm_duty_decoder #(
        .CNT_W      (20),
        .MIN_PERIOD (64),
        .TIMEOUT    (3000)
    ) dut (
        .LPC_CLK33M_GMUX (clk),
        .GMUX_RESET      (rst),
        .PWM_IN          (pwm),
        .LEVEL           (level),
        .LEVEL_UPD       (level_upd),
        .LEVEL_VALID     (level_valid),
        .PWM_IDLE        (pwm_idle)
    );

    always @(negedge clk)
        if (level_upd === 1'b1)
            upd_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Advance n negative edges, then step just past them so upd_cnt is settled.
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic do_period(input int h, input int p);
        pwm = 1'b1;
        cyc(h);
        pwm = 1'b0;
        cyc(p - h);
    endtask

    // The rise opening this period reports the previous period's duty.
    task automatic step(input int h, input int exp_lvl, input string tag);
        int u;
        u = upd_cnt;
        do_period(h, 1000);
        check({tag, "_upd"}, upd_cnt, u + 1);
        check({tag, "_lvl"}, level, exp_lvl);
    endtask

    initial begin
        rst = 1'b1;
        pwm = 1'b0;
        cyc(3);
        check("rst_level", level, 10);
        check("rst_upd", level_upd, 0);
        check("rst_valid", level_valid, 0);
        check("rst_idle", pwm_idle, 0);
        rst = 1'b0;
        cyc(5);

`ifndef PWM_DECODE_HYST_EN
        u0 = upd_cnt;
        do_period(290, 1000);
        check("arm_no_upd", upd_cnt, u0);
        check("arm_valid", level_valid, 0);

        u0 = upd_cnt;
        pwm = 1'b1;
        cyc(22);
        check("lat_upd", upd_cnt, u0 + 1);
        check("lat_level", level, 10);
        check("lat_valid", level_valid, 1);
        cyc(890 - 22);
        pwm = 1'b0;
        cyc(110);

        step(10, 16, "h890");
        step(5, 1, "h10");
        step(259, 0, "h5");
        step(260, 9, "h259");
        step(290, 10, "h260");

        u0 = upd_cnt;
        pwm = 1'b1;
        cyc(20);
        pwm = 1'b0;
        cyc(20);
        check("h290_upd", upd_cnt, u0 + 1);
        check("h290_lvl", level, 10);
        u0 = upd_cnt;
        pwm = 1'b1;
        cyc(30);
        check("glitch_no_upd", upd_cnt, u0);
        check("glitch_lvl", level, 10);
        cyc(240);
        pwm = 1'b0;
        cyc(690);
        step(420, 10, "post_glitch");

        u0 = upd_cnt;
        pwm = 1'b1;
        cyc(25);
        check("h420_lvl", level, 12);
        check("h420_upd", upd_cnt, u0 + 1);
        cyc(3000 - 35);
        check("idle_early", pwm_idle, 0);
        cyc(20);
        check("idle_set", pwm_idle, 1);
        check("idle_lvl", level, 16);
        check("idle_upd", upd_cnt, u0 + 2);
        cyc(200);
        check("idle_single_upd", upd_cnt, u0 + 2);

        pwm = 1'b0;
        cyc(500);
        check("idle_clear", pwm_idle, 0);
        check("idle_valid", level_valid, 1);
        u0 = upd_cnt;
        do_period(420, 1000);
        check("rearm_no_upd", upd_cnt, u0);
        check("rearm_lvl", level, 16);
        u0 = upd_cnt;
        pwm = 1'b1;
        cyc(25);
        check("resume_lvl", level, 12);
        check("resume_upd", upd_cnt, u0 + 1);
        cyc(395);
        pwm = 1'b0;
        cyc(580);

        u0 = upd_cnt;
        pwm = 1'b1;
        cyc(5);
        rst = 1'b1;
        #1;
        check("abort_lvl", level, 10);
        check("abort_valid", level_valid, 0);
        check("abort_upd", level_upd, 0);
        pwm = 1'b0;
        cyc(2);
        rst = 1'b0;
        cyc(40);
        check("abort_no_upd", upd_cnt, u0);
        check("abort_lvl_hold", level, 10);
`else
        do_period(290, 1000);
        do_period(420, 1000);
        do_period(290, 1000);
        check("hyst_mid_upd", upd_cnt, 0);
        check("hyst_mid_lvl", level, 10);
        do_period(420, 1000);
        do_period(420, 1000);
        check("hyst_alt_upd", upd_cnt, 0);
        check("hyst_alt_lvl", level, 10);
        check("hyst_alt_valid", level_valid, 0);
        pwm = 1'b1;
        cyc(25);
        check("hyst_lvl", level, 12);
        check("hyst_upd", upd_cnt, 1);
        check("hyst_valid", level_valid, 1);
        cyc(395);
        pwm = 1'b0;
        cyc(20);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
